// File: rtl/lru_pkg.sv
// lru_pkg: shared FSM state, selector tick type and renormalisation helper.
package lru_pkg;
  typedef enum logic [1:0] {IDLE, LOOKUP, RESPOND, RENORM} state_t;
  localparam int TICK_WIDTH_MAX = 32;
  typedef logic [TICK_WIDTH_MAX-1:0] tick_t;
  function automatic tick_t halve(tick_t t);
    return t == '0 ? '0 : ((t >> 1) == '0 ? tick_t'(1) : t >> 1);
  endfunction
endpackage

// File: rtl/lru_replacement_ctrl_if.sv
// lru_replacement_ctrl_if: touch/invalidate events and victim request/response channel.
interface lru_replacement_ctrl_if #(parameter int SET_WIDTH = 3, parameter int KEY_WIDTH = 2);
  logic                 touch_en;
  logic [SET_WIDTH-1:0] touch_set;
  logic [KEY_WIDTH-1:0] touch_way;
  logic                 touch_ready;
  logic                 inv_en;
  logic [SET_WIDTH-1:0] inv_set;
  logic [KEY_WIDTH-1:0] inv_way;
  logic                 vreq_valid;
  logic [SET_WIDTH-1:0] vreq_set;
  logic                 vreq_ready;
  logic                 vresp_valid;
  logic [KEY_WIDTH-1:0] vresp_way;
  logic                 vresp_ready;
  logic                 busy;
  modport master (
    output touch_en, touch_set, touch_way, inv_en, inv_set, inv_way, vreq_valid, vreq_set, vresp_ready,
    input  touch_ready, vreq_ready, vresp_valid, vresp_way, busy
  );
  modport slave (
    input  touch_en, touch_set, touch_way, inv_en, inv_set, inv_way, vreq_valid, vreq_set, vresp_ready,
    output touch_ready, vreq_ready, vresp_valid, vresp_way, busy
  );
endinterface

// File: rtl/LRUStrategy.sv
// LRUStrategy: picks the way with the smallest tick; ties go to the lowest way index.
module LRUStrategy import lru_pkg::*; #(
  parameter int SET_SIZE  = 4,
  parameter int KEY_WIDTH = 2
) (
  input  tick_t                ticks [SET_SIZE],
  output logic [KEY_WIDTH-1:0] victim
);
  tick_t best;
  always_comb begin
    victim = '0;
    best   = ticks[0];
    for (int i = 1; i < SET_SIZE; i++)
      if (ticks[i] < best) begin
        best   = ticks[i];
        victim = KEY_WIDTH'(i);
      end
  end
endmodule

// File: rtl/lru_replacement_ctrl.sv
// lru_replacement_ctrl: per-set LRU timestamp array, victim selection FSM and
// counter-wrap renormalisation that halves every tick one set per cycle.
module lru_replacement_ctrl import lru_pkg::*; #(
  parameter int SET_COUNT  = 8,
  parameter int SET_SIZE   = 4,
  parameter int SET_WIDTH  = $clog2(SET_COUNT),
  parameter int KEY_WIDTH  = $clog2(SET_SIZE),
  parameter int TICK_WIDTH = 32
) (
  input logic                  clk,
  input logic                  reset,
  lru_replacement_ctrl_if.slave bus
);
  typedef logic [TICK_WIDTH-1:0] tk_t;
  tk_t                  ticks [SET_COUNT][SET_SIZE];
  tk_t                  now;
  state_t               state, state_nx;
  logic                 renorm_pend, touch_acc, last_set;
  logic [SET_WIDTH-1:0] idx, lat_set;
  logic [KEY_WIDTH-1:0] sel_way, way_q;
  tick_t                sel_ticks [SET_SIZE];
  assign touch_acc       = bus.touch_en && bus.touch_ready;
  assign last_set        = idx == SET_WIDTH'(SET_COUNT - 1);
  assign bus.touch_ready = !renorm_pend && state != RENORM;
  assign bus.busy        = renorm_pend || state == RENORM;
  assign bus.vresp_valid = state == RESPOND;
  assign bus.vreq_ready  = state == IDLE && !renorm_pend;
  assign bus.vresp_way   = way_q;
  always_comb begin
    for (int w = 0; w < SET_SIZE; w++)
      sel_ticks[w] = tick_t'(ticks[lat_set][w]);
  end
  LRUStrategy #(.SET_SIZE(SET_SIZE), .KEY_WIDTH(KEY_WIDTH)) u_sel (
    .ticks (sel_ticks),
    .victim(sel_way)
  );
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (bus.vreq_valid && !renorm_pend) ? LOOKUP : (renorm_pend ? RENORM : IDLE);
      LOOKUP:  state_nx = RESPOND;
      RESPOND: state_nx = bus.vresp_ready ? IDLE : RESPOND;
      RENORM:  state_nx = last_set ? IDLE : RENORM;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      now         <= tk_t'(1);
      renorm_pend <= 1'b0;
      idx         <= '0;
      lat_set     <= '0;
      way_q       <= '0;
      for (int s = 0; s < SET_COUNT; s++)
        for (int w = 0; w < SET_SIZE; w++)
          ticks[s][w] <= '0;
    end else begin
      state <= state_nx;
      idx   <= state == RENORM ? idx + 1'b1 : '0;
      if (bus.vreq_valid && bus.vreq_ready) lat_set <= bus.vreq_set;
      if (state == LOOKUP) way_q <= sel_way;
      // at the wrap the counter holds so the wrapping touch still gets the top value
      if (touch_acc) begin
        if (&now) renorm_pend <= 1'b1;
        else now <= now + 1'b1;
      end
      if (state == RENORM && last_set) begin
        now         <= tk_t'(1) << (TICK_WIDTH - 1);
        renorm_pend <= 1'b0;
      end
      for (int s = 0; s < SET_COUNT; s++)
        for (int w = 0; w < SET_SIZE; w++)
          ticks[s][w] <= (bus.inv_en && bus.inv_set == SET_WIDTH'(s) && bus.inv_way == KEY_WIDTH'(w)) ? '0 :
                         (touch_acc && bus.touch_set == SET_WIDTH'(s) && bus.touch_way == KEY_WIDTH'(w)) ? now :
                         (state == RENORM && idx == SET_WIDTH'(s)) ? tk_t'(halve(tick_t'(ticks[s][w]))) :
                         ticks[s][w];
    end
  end
endmodule

// File: tb/tb_lru_replacement_ctrl.sv
// tb_lru_replacement_ctrl: random touches/invalidates/requests against an argmin model with a response scoreboard.
module tb_lru_replacement_ctrl;
  localparam int SETS = 4, WAYS = 4, SW = 2, KW = 2, TW = 4;
  localparam int MAXT = (1 << TW) - 1;
  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;
  lru_replacement_ctrl_if #(.SET_WIDTH(SW), .KEY_WIDTH(KW)) bus ();
  lru_replacement_ctrl #(.SET_COUNT(SETS), .SET_SIZE(WAYS), .TICK_WIDTH(TW)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );
  int total = 0, bad = 0;
  int tk [SETS][WAYS];
  int now, stage, renorm_left;
  bit pend, flush, checking;
  bit exp_tr, exp_vr, exp_busy, exp_vv;
  int q[$];
  function automatic void chk(string name, int act, int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endfunction
  function automatic int victim(int s);
    int b = 0;
    for (int w = 1; w < WAYS; w++) if (tk[s][w] < tk[s][b]) b = w;
    return b;
  endfunction
  function automatic void model_reset();
    for (int s = 0; s < SETS; s++) for (int w = 0; w < WAYS; w++) tk[s][w] = 0;
    now = 1; pend = 0; stage = 0; renorm_left = 0;
  endfunction
  always @(negedge clk) if (checking) begin
    chk("touch_ready", bus.touch_ready, exp_tr);
    chk("vreq_ready", bus.vreq_ready, exp_vr);
    chk("busy", bus.busy, exp_busy);
    chk("vresp_valid", bus.vresp_valid, exp_vv);
    if (bus.vresp_valid) begin
      if (q.size() == 0) begin
        total++; bad++;
        $display("FAIL vresp_unexpected: got way %0d with no request pending", bus.vresp_way);
      end else begin
        chk("vresp_way", bus.vresp_way, q[0]);
        if (bus.vresp_ready) void'(q.pop_front());
      end
    end
  end
  initial begin
    bus.touch_en = 0; bus.touch_set = 0; bus.touch_way = 0;
    bus.inv_en = 0; bus.inv_set = 0; bus.inv_way = 0;
    bus.vreq_valid = 0; bus.vreq_set = 0; bus.vresp_ready = 0;
    model_reset();
    repeat (2) @(posedge clk);
    for (int cyc = 0; cyc < 4000; cyc++) begin
      int ts, tw, is, iw, vs;
      bit te, ie, vv, rr, rs, pend_old;
      @(posedge clk); #1;
      if (flush) begin q.delete(); flush = 0; end
      exp_tr   = !pend && renorm_left == 0;
      exp_vr   = stage == 0 && renorm_left == 0 && !pend;
      exp_busy = pend || renorm_left > 0;
      exp_vv   = stage == 2;
      checking = 1;
      rs = cyc == 0 ? 1'b0 : $urandom_range(0, 299) == 0;
      te = $urandom_range(0, 99) < 60; ts = $urandom_range(0, SETS - 1); tw = $urandom_range(0, WAYS - 1);
      ie = $urandom_range(0, 99) < 15; is = $urandom_range(0, SETS - 1); iw = $urandom_range(0, WAYS - 1);
      if (ie && $urandom_range(0, 3) == 0) begin is = ts; iw = tw; end
      vv = $urandom_range(0, 99) < 40; vs = $urandom_range(0, SETS - 1);
      rr = $urandom_range(0, 99) < 50;
      reset = rs;
      bus.touch_en = te; bus.touch_set = SW'(ts); bus.touch_way = KW'(tw);
      bus.inv_en = ie; bus.inv_set = SW'(is); bus.inv_way = KW'(iw);
      bus.vreq_valid = vv; bus.vreq_set = SW'(vs); bus.vresp_ready = rr;
      if (rs) begin
        model_reset();
        flush = 1;
      end else begin
        pend_old = pend;
        if (te && exp_tr) begin
          tk[ts][tw] = now;
          if (now == MAXT) pend = 1; else now++;
        end
        if (ie) tk[is][iw] = 0;
        if (renorm_left > 0) begin
          renorm_left--;
          if (renorm_left == 0) begin now = 1 << (TW - 1); pend = 0; end
        end else if (stage == 0) begin
          if (vv && !pend_old) begin
            stage = 1;
            q.push_back(victim(vs));
          end else if (pend_old) begin
            renorm_left = SETS;
            for (int s = 0; s < SETS; s++)
              for (int w = 0; w < WAYS; w++)
                tk[s][w] = tk[s][w] == 0 ? 0 : (tk[s][w] / 2 > 1 ? tk[s][w] / 2 : 1);
          end
        end else if (stage == 1) stage = 2;
        else if (rr) stage = 0;
      end
    end
    @(posedge clk); #1;
    checking = 0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/lru_replacement_ctrl.md
Name: lru_replacement_ctrl

Overview:
Per-cache replacement controller. It owns the per-set, per-way LRU timestamp array and a global access counter. It serves victim-selection requests from the cache FSM using the existing LRUStrategy tournament selector. It sits between the cache controller (hit/fill/invalidate events, victim requests) and LRUStrategy, and renormalises timestamps before the counter wraps.

Parameters:
SET_COUNT, `CACHE_S (from cache.vh), number of sets
SET_SIZE, `CACHE_E, ways per set
SET_WIDTH, $clog2(SET_COUNT), set index width
KEY_WIDTH, $clog2(SET_SIZE), way index width
TICK_WIDTH, 32, timestamp width (<=32, zero-extended into selector)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
touch_en  in  1  hit or fill commit: mark way most-recently used
touch_set  in  SET_WIDTH  set of touch
touch_way  in  KEY_WIDTH  way of touch
touch_ready  out  1  touch accepted this cycle when touch_en && touch_ready
inv_en  in  1  invalidate way (tick := 0)
inv_set  in  SET_WIDTH  set of invalidate
inv_way  in  KEY_WIDTH  way of invalidate
vreq_valid  in  1  victim request
vreq_set  in  SET_WIDTH  set to choose victim from
vreq_ready  out  1  request accepted when vreq_valid && vreq_ready
vresp_valid  out  1  victim result valid
vresp_way  out  KEY_WIDTH  chosen victim way
vresp_ready  in  1  consumer takes result
busy  out  1  renormalisation in progress or pending

Behaviour:
- Clock is clk; reset is synchronous, active-high.
- Reset (also mid-operation): all ticks 0; now := 1; FSM IDLE; renorm_pend 0; vresp_valid 0, vresp_way 0, busy 0. Any in-flight request is dropped.
- Tick 0 means invalid or never used. The selector picks the minimum tick, so invalid ways are chosen first. Ties resolve to the lowest way index.
- Touch accepted:
  - tick[set][way] := now and now := now+1 at the clock edge.
  - If now == all-ones at acceptance: write the tick, hold now, set renorm_pend.
- Invalidate: tick[set][way] := 0. It is always accepted, including during RENORM.
- Same-cycle touch and inv on the same set/way: inv wins.
- touch_ready = !renorm_pend && state != RENORM.
- FSM states IDLE, LOOKUP, RESPOND, RENORM.
- IDLE:
  - vreq_ready = !renorm_pend.
  - On accept: latch set, go to LOOKUP.
  - Else if renorm_pend: go to RENORM with idx := 0.
- LOOKUP (1 cycle):
  - Drive the latched set's register values to the selector (same-cycle touches are not visible).
  - Register the result into vresp_way; go to RESPOND.
- RESPOND:
  - vresp_valid = 1; vresp_way is stable until vresp_ready.
  - On vresp_ready: go to IDLE.
- Latency: accept at cycle T -> vresp_valid at T+2, at the earliest.
- RENORM (SET_COUNT cycles, one set per cycle, idx 0..SET_COUNT-1):
  - For each way: tick := (tick==0) ? 0 : max(tick>>1, 1).
  - After the last set: now := 2^(TICK_WIDTH-1), renorm_pend := 0, go to IDLE.
  - Relative order is preserved non-strictly (monotone). Invalid ways stay 0.
- busy = renorm_pend || state==RENORM.
- vreq_ready is 0 outside IDLE, and 0 in IDLE while renorm_pend.
- A wrap touch during LOOKUP/RESPOND defers RENORM until the FSM returns to IDLE.
- Invalidates during RENORM to a set not yet processed are then halved (0 stays 0). To an already-processed set, they apply directly.

Decomposition:
- cache.vh keeps `CACHE_S/`CACHE_E.
- Add a shared package lru_pkg: state enum typedef (IDLE/LOOKUP/RESPOND/RENORM) and tick_t typedef parameterised by TICK_WIDTH.
- One sub-module instance: the existing LRUStrategy, fed the selected set's ticks zero-extended to 32 bits.
- The tick array is a register array in this block.

Test Plan:
1. Reset; vreq set 0 (SET_SIZE=4) -> vresp_valid at T+2, vresp_way=0 (all ticks 0, lowest index).
2. Touch set 2 ways 0,1,2,3 in order; vreq set 2 -> way 0. Touch way 0, vreq -> way 1.
3. Touch all 4 ways of set 1, inv way 2, vreq set 1 -> way 2. Same-cycle touch+inv of way 3 -> tick 0, next vreq -> way 2.
4. Hold vresp_ready=0 for 5 cycles -> vresp_valid and vresp_way stable, vreq_ready=0. Then ready -> IDLE next cycle.
5. TICK_WIDTH=4: touch until now=15 -> busy=1, touch_ready=0, RENORM lasts SET_COUNT cycles. Ticks {12,13,14,15} -> {6,6,7,7}, now=8, LRU order preserved (vreq -> lowest tick way).
6. Assert reset during RESPOND and during RENORM -> next cycle all outputs 0, ticks 0, now=1, vreq_ready=1.
